// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, opcode check.
package alu_pkg;

    // Supported ALU opcodes
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True when op is one of the eight supported codes
    function automatic logic op_is_valid(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_is_valid = 1'b1;
            default:                        op_is_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/modulo_alu.sv
// Combinational ALU: wrap-around arithmetic, logic ops and shifts.
// Unsupported opcodes produce all ones.
module modulo_alu
    import alu_pkg::*;
#(
    parameter int lenD = 8,
    parameter int lenO = 6
) (
    input  logic [lenD-1:0] i_a,
    input  logic [lenD-1:0] i_b,
    input  logic [lenO-1:0] i_op,
    output logic [lenD-1:0] o_y
);

    // Opcode decode and result select; shift amount is the full b operand
    always_comb begin
        o_y = '1;
        case (i_op)
            OP_ADD: o_y = i_a + i_b;
            OP_SUB: o_y = i_a - i_b;
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SRA: o_y = $signed(i_a) >>> i_b;
            OP_SRL: o_y = i_a >> i_b;
            OP_NOR: o_y = ~(i_a | i_b);
            default: o_y = '1;
        endcase
    end

endmodule

// File: rtl/modulo_alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE accepts, EXEC captures the result,
// RESP holds it until the owner takes it.
module modulo_alu_arbiter
    import alu_pkg::*;
#(
    parameter int lenD = 8,
    parameter int lenO = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [lenD-1:0] r0_a,
    input  logic [lenD-1:0] r0_b,
    input  logic [lenO-1:0] r0_op,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [lenD-1:0] r1_a,
    input  logic [lenD-1:0] r1_b,
    input  logic [lenO-1:0] r1_op,
    output logic            rsp_valid,
    output logic            rsp_id,
    input  logic            rsp_ready,
    output logic [lenD-1:0] rsp_data,
    output logic            rsp_err
);

    logic [1:0]      r_state;
    logic            r_ptr;
    logic            r_id;
    logic [lenD-1:0] r_a;
    logic [lenD-1:0] r_b;
    logic [lenO-1:0] r_op;
    logic [lenD-1:0] r_data;
    logic            r_err;

    logic            w_idle;
    logic            w_acc0;
    logic            w_acc1;
    logic [lenD-1:0] w_alu_y;

    // Grant: a lone valid requester always wins; on contention the pointer decides.
    // Ready is also held low while reset is asserted.
    assign w_idle   = rst_n && (r_state == ST_IDLE);
    assign r0_ready = w_idle && r0_valid && (!r1_valid || !r_ptr);
    assign r1_ready = w_idle && r1_valid && (!r0_valid ||  r_ptr);
    assign w_acc0   = r0_ready && r0_valid;
    assign w_acc1   = r1_ready && r1_valid;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;

    modulo_alu #(
        .lenD (lenD),
        .lenO (lenO)
    ) u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_alu_y)
    );

    // Handshake FSM, operand latch, round-robin pointer and result hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_a     <= w_acc1 ? r1_a  : r0_a;
                        r_b     <= w_acc1 ? r1_b  : r0_b;
                        r_op    <= w_acc1 ? r1_op : r0_op;
                        r_id    <= w_acc1;
                        r_ptr   <= ~w_acc1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_data  <= w_alu_y;
                    r_err   <= ~op_is_valid(r_op);
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_alu_arbiter.sv
// Directed bench for modulo_alu_arbiter: inputs driven and outputs sampled
// on the falling edge, away from the active rising edge.
module tb_modulo_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_valid, r1_valid;
    logic       r0_ready, r1_ready;
    logic [7:0] r0_a, r0_b, r1_a, r1_b;
    logic [5:0] r0_op, r1_op;
    logic       rsp_valid, rsp_id, rsp_ready, rsp_err;
    logic [7:0] rsp_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    modulo_alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Reset for two rising edges, released on a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one op from a requester; returns cycles from accept to rsp_valid (-1 on timeout).
    // Returns at the falling edge where rsp_valid is first seen.
    task automatic send(input bit who, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] op, output int lat);
        int n;
        @(negedge clk);
        if (who) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
        else     begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
        #1;
        n = 0;
        while (!(who ? r1_ready : r0_ready) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) begin
            lat = -1; r0_valid = 1'b0; r1_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (who) r1_valid = 1'b0; else r0_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) lat = -1;
    endtask

    // Take the held response for one cycle
    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_chk++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
        n_chk++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_chk++; if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {r0_ready, r1_ready}); end
    endtask

    task automatic test_single_add();
        int lat;
        do_reset();
        send(1'b0, 8'h05, 8'h03, 6'b100000, lat);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", lat); end
        n_chk++; if (rsp_data !== 8'h08) begin n_fail++; $display("FAIL add_data got %h want 08", rsp_data); end
        n_chk++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL add_id got %b want 0", rsp_id); end
        n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_err got %b want 0", rsp_err); end
        consume();
    endtask

    task automatic test_contention();
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 8'h03; r0_b = 8'h05; r0_op = 6'b100010;
        r1_valid = 1'b1; r1_a = 8'hF0; r1_b = 8'h0F; r1_op = 6'b100110;
        #1;
        n_chk++; if ({r0_ready, r1_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_first_grant got %b want 10", {r0_ready, r1_ready}); end
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        n_chk++; if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_exec_ready got %b want 0", r1_ready); end
        @(negedge clk);
        n_chk++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'hFE}) begin n_fail++; $display("FAIL cont_rsp0 got v%b id%b %h want v1 id0 fe", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        #1;
        n_chk++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL cont_second_grant got %b want 1", r1_ready); end
        @(negedge clk);
        r1_valid = 1'b0;
        @(negedge clk);
        n_chk++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'hFF}) begin n_fail++; $display("FAIL cont_rsp1 got v%b id%b %h want v1 id1 ff", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_fairness();
        bit g[4];
        int ng;
        bit both;
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 8'h01; r0_b = 8'h01; r0_op = 6'b100000;
        r1_valid = 1'b1; r1_a = 8'h02; r1_b = 8'h02; r1_op = 6'b100000;
        ng = 0; both = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (r0_ready && r1_ready) both = 1'b1;
            if (r0_ready) begin g[ng] = 1'b0; ng++; end
            else if (r1_ready) begin g[ng] = 1'b1; ng++; end
            @(negedge clk);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        n_chk++; if (ng !== 4) begin n_fail++; $display("FAIL fair_grant_count got %0d want 4", ng); end
        n_chk++; if (both !== 1'b0) begin n_fail++; $display("FAIL fair_double_ready got %b want 0", both); end
        n_chk++; if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin n_fail++; $display("FAIL fair_order got %b want 0101", {g[0], g[1], g[2], g[3]}); end
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_shift_err();
        int lat;
        do_reset();
        send(1'b0, 8'h80, 8'h01, 6'b000011, lat);
        n_chk++; if ({lat == 2, rsp_data, rsp_err} !== {1'b1, 8'hC0, 1'b0}) begin n_fail++; $display("FAIL sra got lat%0d %h err%b want lat2 c0 err0", lat, rsp_data, rsp_err); end
        consume();
        send(1'b1, 8'h80, 8'h01, 6'b000010, lat);
        n_chk++; if ({lat == 2, rsp_data, rsp_id, rsp_err} !== {1'b1, 8'h40, 1'b1, 1'b0}) begin n_fail++; $display("FAIL srl got lat%0d %h id%b err%b want lat2 40 id1 err0", lat, rsp_data, rsp_id, rsp_err); end
        consume();
        send(1'b0, 8'h12, 8'h34, 6'b111111, lat);
        n_chk++; if ({lat == 2, rsp_data, rsp_err} !== {1'b1, 8'hFF, 1'b1}) begin n_fail++; $display("FAIL bad_op got lat%0d %h err%b want lat2 ff err1", lat, rsp_data, rsp_err); end
        consume();
        send(1'b0, 8'h0C, 8'h03, 6'b100111, lat);
        n_chk++; if ({rsp_data, rsp_err} !== {8'hF0, 1'b0}) begin n_fail++; $display("FAIL nor got %h err%b want f0 err0", rsp_data, rsp_err); end
        consume();
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 8'h03; r0_b = 8'h04; r0_op = 6'b100000;
        #1;
        n_chk++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_accept0 got %b want 1", r0_ready); end
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_a = 8'h10; r1_b = 8'h01; r1_op = 6'b100010;
        #1;
        n_chk++; if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_exec_ready got %b want 0", r1_ready); end
        @(negedge clk);
        #1;
        n_chk++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h07}) begin n_fail++; $display("FAIL stall_rsp got v%b id%b %h want v1 id0 07", rsp_valid, rsp_id, rsp_data); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_chk++; if ({rsp_valid, rsp_id, rsp_data, rsp_err, r0_ready, r1_ready} !== {1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL stall_hold%0d got v%b id%b %h err%b rdy%b%b want v1 id0 07 err0 rdy00", c, rsp_valid, rsp_id, rsp_data, rsp_err, r0_ready, r1_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        n_chk++; if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_resp_ready got %b want 0", r1_ready); end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_chk++; if ({rsp_valid, r1_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_next_accept got v%b rdy%b want v0 rdy1", rsp_valid, r1_ready); end
        @(negedge clk);
        r1_valid = 1'b0;
        @(negedge clk);
        n_chk++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'h0F}) begin n_fail++; $display("FAIL stall_r1_rsp got v%b id%b %h want v1 id1 0f", rsp_valid, rsp_id, rsp_data); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        do_reset();
        send(1'b1, 8'hA5, 8'h0F, 6'b100101, lat);
        n_chk++; if (rsp_data !== 8'hAF) begin n_fail++; $display("FAIL rmid_pre_or got %h want af", rsp_data); end
        consume();
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 8'h06; r0_b = 8'h05; r0_op = 6'b100100;
        #1;
        n_chk++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got %b want 1", r0_ready); end
        @(negedge clk);
        r0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if ({rsp_valid, rsp_id, rsp_data, rsp_err, r0_ready, r1_ready} !== 13'b0) begin n_fail++; $display("FAIL rmid_outputs got v%b id%b %h err%b rdy%b%b want all 0", rsp_valid, rsp_id, rsp_data, rsp_err, r0_ready, r1_ready); end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_discard got rsp_valid %b want 0", seen); end
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        n_chk++; if ({r0_ready, r1_ready} !== 2'b10) begin n_fail++; $display("FAIL rmid_ptr got %b want 10", {r0_ready, r1_ready}); end
        r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0;
        test_reset();
        test_single_add();
        test_contention();
        test_fairness();
        test_shift_err();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
